// File: rtl/conv2_fmap_streamer_pkg.sv
// Shared types and constants for the conv2 feature-map streamer and its counter.
// popcount_ch is only referenced when CONV2_STREAM_POPCOUNT_EN is defined.
package conv2_stream_pkg;

    localparam int CONV2_ROWS = 4;
    localparam int CONV2_COLS = 4;
    localparam int CONV2_CH   = 60;
    localparam int CONV2_PC_W = $clog2(CONV2_CH + 1);

    typedef enum logic {
        ST_EMPTY,
        ST_STREAM
    } conv2_stream_state_e;

    function automatic logic [CONV2_PC_W-1:0] popcount_ch(input logic [CONV2_CH-1:0] v);
        logic [CONV2_PC_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < CONV2_CH; i++) begin
            n = n + CONV2_PC_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/conv2_fmap_streamer_if.sv
// Beat stream from the conv2 fmap streamer to the dense layer (valid/ready).
// CONV2_STREAM_POPCOUNT_EN adds the per-beat out_popcount signal.
interface conv2_stream_if
    import conv2_stream_pkg::*;
#(
    parameter int CH     = CONV2_CH,
    parameter int BEAT_W = 4
);

    logic [CH-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [BEAT_W-1:0] out_index;
`ifdef CONV2_STREAM_POPCOUNT_EN
    logic [$clog2(CH+1)-1:0] out_popcount;

    modport master (
        output out_data, out_valid, out_last, out_index, out_popcount,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_last, out_index, out_popcount,
        output out_ready
    );
`else
    modport master (
        output out_data, out_valid, out_last, out_index,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_last, out_index,
        output out_ready
    );
`endif

endinterface

// File: rtl/conv2_fmap_streamer_beat_counter.sv
// Row-major row/col beat counter for fmap readers; wraps to [0][0] after the last beat.
module conv2_beat_counter
    import conv2_stream_pkg::*;
#(
    parameter  int ROWS   = CONV2_ROWS,
    parameter  int COLS   = CONV2_COLS,
    parameter  int BEAT_W = 4,
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic [BEAT_W-1:0] index,
    output logic              last
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             row_end, col_end;

    assign row_end = (row_q == ROW_W'(ROWS - 1));
    assign col_end = (col_q == COL_W'(COLS - 1));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row   = row_q;
    assign col   = col_q;
    assign index = BEAT_W'(int'(row_q) * COLS + int'(col_q));
    assign last  = row_end && col_end;

endmodule

// File: rtl/conv2_fmap_streamer.sv
// Snapshots the conv2 output fmap on done_conv and streams it one position per beat.
// CONV2_STREAM_POPCOUNT_EN adds out_popcount (per beat) and map_popcount (per map).
module conv2_fmap_streamer
    import conv2_stream_pkg::*;
#(
    parameter int ROWS   = CONV2_ROWS,
    parameter int COLS   = CONV2_COLS,
    parameter int CH     = CONV2_CH,
    parameter int BEAT_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           fmap_valid,
    input  logic           fmap_in [0:ROWS-1][0:COLS-1][0:CH-1],
    output logic           fmap_ready,
    conv2_stream_if.master out_if,
    output logic           overflow
`ifdef CONV2_STREAM_POPCOUNT_EN
    ,
    output logic [$clog2(ROWS*COLS*CH+1)-1:0] map_popcount
`endif
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    conv2_stream_state_e state_q, state_d;

    logic [CH-1:0]     fmap_in_vec [ROWS][COLS];
    logic [CH-1:0]     fmap_buf_q  [ROWS][COLS];
    logic [CH-1:0]     fmap_buf_d  [ROWS][COLS];
    logic              overflow_q, overflow_d;
    logic              stream_valid;
    logic              capture;
    logic              beat_xfer;
    logic              beat_last;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [BEAT_W-1:0] beat_index;

    always_comb begin
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                for (int unsigned k = 0; k < CH; k++) begin
                    fmap_in_vec[r][c][k] = fmap_in[r][c][k];
                end
            end
        end
    end

    // A pulse is only taken when empty; anything arriving mid-stream is dropped.
    assign capture   = fmap_valid && (state_q == ST_EMPTY);
    assign beat_xfer = stream_valid && out_if.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY:  if (fmap_valid) state_d = ST_STREAM;
            ST_STREAM: if (beat_xfer && beat_last) state_d = ST_EMPTY;
            default:   state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        fmap_ready   = 1'b0;
        stream_valid = 1'b0;
        case (state_q)
            ST_EMPTY:  fmap_ready   = 1'b1;
            ST_STREAM: stream_valid = 1'b1;
            default:   fmap_ready   = 1'b0;
        endcase
    end

    always_comb begin
        fmap_buf_d = fmap_buf_q;
        if (capture) begin
            fmap_buf_d = fmap_in_vec;
        end
    end

    always_ff @(posedge clk) begin
        fmap_buf_q <= fmap_buf_d;
    end

    always_comb begin
        overflow_d = overflow_q;
        if (fmap_valid && (state_q == ST_STREAM)) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    conv2_beat_counter #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .BEAT_W (BEAT_W)
    ) u_beat_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (capture),
        .advance (beat_xfer),
        .row     (row),
        .col     (col),
        .index   (beat_index),
        .last    (beat_last)
    );

    assign out_if.out_data  = fmap_buf_q[row][col];
    assign out_if.out_valid = stream_valid;
    assign out_if.out_last  = beat_last;
    assign out_if.out_index = beat_index;
    assign overflow         = overflow_q;

`ifdef CONV2_STREAM_POPCOUNT_EN
    localparam int MAP_PC_W = $clog2(ROWS*COLS*CH+1);

    logic [MAP_PC_W-1:0] map_popcount_q, map_popcount_d;
    logic [MAP_PC_W-1:0] map_pc_sum;

    assign out_if.out_popcount = popcount_ch(out_if.out_data);

    // Summed from the incoming map so the total is ready the first STREAM cycle.
    always_comb begin
        map_pc_sum = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                map_pc_sum = map_pc_sum + MAP_PC_W'(popcount_ch(fmap_in_vec[r][c]));
            end
        end
    end

    always_comb begin
        map_popcount_d = map_popcount_q;
        if (capture) begin
            map_popcount_d = map_pc_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            map_popcount_q <= '0;
        end else begin
            map_popcount_q <= map_popcount_d;
        end
    end

    assign map_popcount = map_popcount_q;
`endif

endmodule

// File: tb/tb_conv2_fmap_streamer.sv
// Scoreboard bench for conv2_fmap_streamer: stimulus pushes expected beats, a negedge monitor checks them.
// Build with +define+CONV2_STREAM_POPCOUNT_EN to also cover the popcount outputs.
module tb_conv2_fmap_streamer;

    localparam int R = 4;
    localparam int C = 4;
    localparam int K = 60;

    logic clk        = 1'b0;
    logic reset      = 1'b1;
    logic fmap_valid = 1'b0;
    logic fmap_in [0:R-1][0:C-1][0:K-1];
    logic fmap_ready;
    logic overflow;
`ifdef CONV2_STREAM_POPCOUNT_EN
    logic [9:0] map_popcount;
`endif

    conv2_stream_if #(.CH(K), .BEAT_W(4)) sif ();

    conv2_fmap_streamer #(
        .ROWS   (R),
        .COLS   (C),
        .CH     (K),
        .BEAT_W (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fmap_valid   (fmap_valid),
        .fmap_in      (fmap_in),
        .fmap_ready   (fmap_ready),
        .out_if       (sif),
        .overflow     (overflow)
`ifdef CONV2_STREAM_POPCOUNT_EN
        ,
        .map_popcount (map_popcount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [K-1:0] data;
        logic [3:0]   idx;
        logic         last;
        int           pc;
    } beat_t;

    beat_t exp_q[$];
    int n_vec  = 0;
    int n_err  = 0;
    int n_xfer = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic pat_bit(input int p, input int r, input int c, input int k);
        case (p)
            1:       return ((r*4 + c + k) % 3) == 0;
            2:       return ((r*7 + c*3 + k) % 5) == 1;
            3:       return ((r + 2*c + k) % 4) != 2;
            4:       return (k % (r + c + 2)) == 0;
            5:       return ((r ^ c ^ k) & 1) == 1;
            6:       return ((k + r) % 6) < 2;
            7:       return 1'b1;
            8:       return 1'b0;
            default: return ((k + c) % 2) == 1;
        endcase
    endfunction

    task automatic load_map(input int p, input bit push);
        beat_t b;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                b.data = '0;
                b.pc   = 0;
                for (int k = 0; k < K; k++) begin
                    fmap_in[r][c][k] = pat_bit(p, r, c, k);
                    b.data[k]        = pat_bit(p, r, c, k);
                    if (pat_bit(p, r, c, k)) b.pc++;
                end
                b.idx  = 4'(r*C + c);
                b.last = (r == R-1) && (c == C-1);
                if (push) exp_q.push_back(b);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name, input int limit, output int n);
        n = 0;
        while (!fmap_ready && n < limit) begin
            step();
            n++;
        end
        chk({name, "_ready_seen"}, 64'(fmap_ready), 64'd1);
    endtask

    task automatic capture_map(input int p);
        load_map(p, 1'b1);
        fmap_valid = 1'b1;
        step();
        fmap_valid = 1'b0;
    endtask

    // Monitor: pops one expected beat per transfer and checks hold-stability under stall.
    logic [K-1:0] h_data;
    logic [3:0]   h_idx;
    logic         h_last;
    bit           prev_stall = 1'b0;
    bit           prev_rst   = 1'b0;

    always @(negedge clk) begin
        beat_t e;
        if (prev_stall && !prev_rst) begin
            chk("stall_valid", 64'(sif.out_valid), 64'd1);
            chk("stall_data",  64'(sif.out_data),  64'(h_data));
            chk("stall_index", 64'(sif.out_index), 64'(h_idx));
            chk("stall_last",  64'(sif.out_last),  64'(h_last));
        end
        prev_stall = sif.out_valid && !sif.out_ready && !reset;
        prev_rst   = reset;
        h_data     = sif.out_data;
        h_idx      = sif.out_index;
        h_last     = sif.out_last;
        if (sif.out_valid && sif.out_ready && !reset) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got index %0d expected no transfer", sif.out_index);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data",  64'(sif.out_data),  64'(e.data));
                chk("beat_index", 64'(sif.out_index), 64'(e.idx));
                chk("beat_last",  64'(sif.out_last),  64'(e.last));
`ifdef CONV2_STREAM_POPCOUNT_EN
                chk("beat_popcount", 64'(sif.out_popcount), 64'(e.pc));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int x0;

        sif.out_ready = 1'b0;
        load_map(8, 1'b0);

        // reset state
        reset = 1'b1;
        step();
        step();
        chk("rst_fmap_ready", 64'(fmap_ready),    64'd1);
        chk("rst_out_valid",  64'(sif.out_valid), 64'd0);
        chk("rst_out_last",   64'(sif.out_last),  64'd0);
        chk("rst_out_index",  64'(sif.out_index), 64'd0);
        chk("rst_overflow",   64'(overflow),      64'd0);
`ifdef CONV2_STREAM_POPCOUNT_EN
        chk("rst_map_popcount", 64'(map_popcount), 64'd0);
`endif
        reset = 1'b0;
        step();

        // full-throughput pass
        sif.out_ready = 1'b1;
        x0 = n_xfer;
        capture_map(1);
        chk("t1_valid",      64'(sif.out_valid), 64'd1);
        chk("t1_first_idx",  64'(sif.out_index), 64'd0);
        chk("t1_busy",       64'(fmap_ready),    64'd0);
        wait_ready("t1", 40, n);
        chk("t1_ready_edges", 64'(n), 64'd16);
        chk("t1_xfers",      64'(n_xfer - x0),   64'd16);
        chk("t1_queue",      64'(exp_q.size()),  64'd0);

        // ready pattern 1,0,0,1
        x0 = n_xfer;
        capture_map(2);
        n = 0;
        while (!fmap_ready && n < 200) begin
            sif.out_ready = (n % 4 == 0) || (n % 4 == 3);
            step();
            n++;
        end
        chk("t2_ready_seen", 64'(fmap_ready),   64'd1);
        chk("t2_xfers",      64'(n_xfer - x0),  64'd16);
        chk("t2_queue",      64'(exp_q.size()), 64'd0);
        sif.out_ready = 1'b1;

        // pulse coincident with final transfer is dropped; next pulse captures
        capture_map(4);
        repeat (15) step();
        chk("t4_idx15", 64'(sif.out_index), 64'd15);
        chk("t4_last",  64'(sif.out_last),  64'd1);
        load_map(9, 1'b0);
        fmap_valid = 1'b1;
        step();
        fmap_valid = 1'b0;
        chk("t4_overflow",   64'(overflow),      64'd1);
        chk("t4_empty_rdy",  64'(fmap_ready),    64'd1);
        chk("t4_empty_vld",  64'(sif.out_valid), 64'd0);
        capture_map(5);
        chk("t4_recap_vld",  64'(sif.out_valid), 64'd1);
        chk("t4_recap_idx",  64'(sif.out_index), 64'd0);
        wait_ready("t4", 40, n);
        chk("t4_queue",      64'(exp_q.size()),  64'd0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_overflow", 64'(overflow), 64'd0);

        // second pulse on beat 7
        capture_map(3);
        repeat (7) step();
        chk("t3_idx7", 64'(sif.out_index), 64'd7);
        load_map(9, 1'b0);
        fmap_valid = 1'b1;
        step();
        fmap_valid = 1'b0;
        chk("t3_overflow", 64'(overflow),      64'd1);
        chk("t3_valid",    64'(sif.out_valid), 64'd1);
        chk("t3_idx8",     64'(sif.out_index), 64'd8);
        wait_ready("t3", 40, n);
        chk("t3_sticky",   64'(overflow),      64'd1);
        chk("t3_queue",    64'(exp_q.size()),  64'd0);

        // reset mid-stream during stall
        capture_map(6);
        repeat (5) step();
        chk("t5_idx5", 64'(sif.out_index), 64'd5);
        sif.out_ready = 1'b0;
        step();
        step();
        exp_q.delete();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_valid",    64'(sif.out_valid), 64'd0);
        chk("t5_ready",    64'(fmap_ready),    64'd1);
        chk("t5_index",    64'(sif.out_index), 64'd0);
        chk("t5_overflow", 64'(overflow),      64'd0);
        sif.out_ready = 1'b1;
        x0 = n_xfer;
        capture_map(1);
        chk("t5_new_idx",  64'(sif.out_index), 64'd0);
        wait_ready("t5", 40, n);
        chk("t5_xfers",    64'(n_xfer - x0),   64'd16);
        chk("t5_queue",    64'(exp_q.size()),  64'd0);

`ifdef CONV2_STREAM_POPCOUNT_EN
        capture_map(7);
        chk("pc_ones_map", 64'(map_popcount), 64'd960);
        wait_ready("pc_ones", 40, n);
        capture_map(8);
        chk("pc_zeros_map", 64'(map_popcount), 64'd0);
        wait_ready("pc_zeros", 40, n);
        chk("pc_queue", 64'(exp_q.size()), 64'd0);
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
